// File: rtl/sel_arb_mux.sv
// -----------------------------------------------------------------------------
// sel_arb_mux
//
// N-channel selection multiplexer with a registered, valid/ready-handshaked
// output stage. The selection policy is fixed at elaboration time:
//   MODE 0 : fixed priority, lowest set request index wins
//   MODE 1 : unique, lowest index wins and a multi-hit raises err_multi
//   MODE 2 : round robin, search starts one past the last granted channel
// Missing-selection (full-case) and multi-hit (parallel-case) violations are
// reported as registered one-cycle pulses plus a saturating error counter.
//
// Parameters
//   N      number of request channels (2..16)
//   W      data width per channel
//   MODE   selection policy (see above)
//   CNT_W  width of the saturating error counter
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req_valid   per-channel request
//   req_data    channel i data lives in bits [i*W +: W]
//   req_ready   one-hot grant (combinational)
//   req_expect  a selection is required this cycle (full-case check)
//   out_valid   output register holds a word
//   out_data    selected word
//   out_idx     index of the channel that supplied out_data
//   out_ready   downstream accepts the output word
//   err_multi   pulse: unique mode saw more than one request at grant
//   err_none    pulse: req_expect with no request while a slot was open
//   err_cnt     saturating count of error cycles
//   err_clr     synchronous clear of err_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module sel_arb_mux #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [N*W-1:0]         req_data,
  output logic [N-1:0]           req_ready,
  input  logic                   req_expect,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_idx,
  input  logic                   out_ready,
  output logic                   err_multi,
  output logic                   err_none,
  output logic [CNT_W-1:0]       err_cnt,
  input  logic                   err_clr
);

  localparam int IW = $clog2(N);

  localparam int MODE_PRIORITY = 0;
  localparam int MODE_UNIQUE   = 1;
  localparam int MODE_RR       = 2;

  // Round-robin pointer starts at the last channel so channel 0 is served first.
  localparam logic [IW-1:0]    PTR_RST = IW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     VEC_ONE = {{(N-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Selection helpers
  // ---------------------------------------------------------------------------

  // Lowest set index of v; 0 when v is empty (caller gates with |v).
  function automatic logic [IW-1:0] pick_lowest(input logic [N-1:0] v);
    logic found;
    pick_lowest = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && v[i]) begin
        pick_lowest = IW'(i);
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // First set index searching p+1, p+2, ... wrapping N-1 -> 0. Because the
  // search covers N positions it ends on p itself, so a lone request from the
  // previously granted channel is still served.
  function automatic logic [IW-1:0] pick_rr(input logic [N-1:0] v,
                                            input logic [IW-1:0] p);
    logic found;
    int   idx;
    pick_rr = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(p) + k) % N;
      if (!found && v[idx]) begin
        pick_rr = IW'(idx);
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // One-hot encoding of a channel index.
  function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] g);
    to_onehot    = '0;
    to_onehot[g] = 1'b1;
  endfunction

  // True when more than one bit of v is set (clearing the lowest set bit
  // leaves something behind).
  function automatic logic multi_hit(input logic [N-1:0] v);
    multi_hit = ((v & (v - VEC_ONE)) != '0);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q,  out_data_d;
  logic [IW-1:0]     out_idx_q,   out_idx_d;
  logic [IW-1:0]     ptr_q,       ptr_d;
  logic              err_multi_q, err_multi_d;
  logic              err_none_q,  err_none_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational grant
  // ---------------------------------------------------------------------------
  logic              load_en;
  logic              any_req;
  logic              grant_en;
  logic [IW-1:0]     grant_idx;
  logic [W-1:0]      grant_data;

  // Open slot, request presence and the mode-dependent winner.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    any_req  = |req_valid;
    // No grant while in reset so nothing is consumed from a requester.
    grant_en = load_en && any_req && !rst;
    case (MODE)
      MODE_RR:       grant_idx = pick_rr(req_valid, ptr_q);
      MODE_UNIQUE:   grant_idx = pick_lowest(req_valid);
      MODE_PRIORITY: grant_idx = pick_lowest(req_valid);
      default:       grant_idx = pick_lowest(req_valid);
    endcase
  end

  // Data mux for the winning channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        grant_data = req_data[i*W +: W];
      end else begin
        grant_data = grant_data;
      end
    end
  end

  // One-hot grant back to the requesters.
  always_comb begin
    if (grant_en) begin
      req_ready = to_onehot(grant_idx);
    end else begin
      req_ready = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Output register: load on grant, drain when accepted with nothing new.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (grant_en) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_idx_d   = grant_idx;
    end else if (load_en && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Round-robin pointer follows the last granted channel.
  always_comb begin
    if (grant_en && (MODE == MODE_RR)) begin
      ptr_d = grant_idx;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Error detection: only evaluated while the output slot is open.
  always_comb begin
    if (grant_en && (MODE == MODE_UNIQUE)) begin
      err_multi_d = multi_hit(req_valid);
    end else begin
      err_multi_d = 1'b0;
    end
    if (load_en && req_expect && !any_req && !rst) begin
      err_none_d = 1'b1;
    end else begin
      err_none_d = 1'b0;
    end
  end

  // Saturating counter; a simultaneous multi and none error counts once and
  // a clear overrides any increment in the same cycle.
  always_comb begin
    if (err_clr) begin
      err_cnt_d = '0;
    end else if ((err_multi_d || err_none_d) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // All state with synchronous reset; reset discards any held output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      ptr_q       <= PTR_RST;
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
      err_multi_q <= err_multi_d;
      err_none_q  <= err_none_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign err_multi = err_multi_q;
  assign err_none  = err_none_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sel_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_sel_arb_mux
//
// Three instances (priority, unique, round robin; N=4, W=8, CNT_W=8) share
// clock, reset, data bus, out_ready and err_clr; each has its own req_valid and
// req_expect. Stimulus pushes the hand-computed {instance, idx, data} of every
// expected output word into a queue; a negedge monitor pops and compares on
// every accepted output (out_valid && out_ready). Combinational grants, error
// pulses and the counter are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_sel_arb_mux;

  logic        clk;
  logic        rst;
  logic        out_ready;
  logic        err_clr;
  logic [31:0] req_data;

  logic [3:0]  req_valid  [3];
  logic        req_expect [3];
  logic [3:0]  req_ready  [3];
  logic        out_valid  [3];
  logic [7:0]  out_data   [3];
  logic [1:0]  out_idx    [3];
  logic        err_multi  [3];
  logic        err_none   [3];
  logic [7:0]  err_cnt    [3];

  int tests = 0;
  int fails = 0;

  logic [11:0] sb_q[$];

  // Directed vectors
  logic [3:0] pv  [4]  = '{4'b1010, 4'b1100, 4'b1000, 4'b1111};
  logic [1:0] pix [4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rv  [11] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                           4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
  logic [1:0] rix [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2,
                           2'd3, 2'd0, 2'd1, 2'd3};

  sel_arb_mux #(.N(4), .W(8), .MODE(0), .CNT_W(8)) u_prio (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_data(req_data),
    .req_ready(req_ready[0]), .req_expect(req_expect[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_idx(out_idx[0]), .out_ready(out_ready),
    .err_multi(err_multi[0]), .err_none(err_none[0]), .err_cnt(err_cnt[0]),
    .err_clr(err_clr));

  sel_arb_mux #(.N(4), .W(8), .MODE(1), .CNT_W(8)) u_uniq (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_data(req_data),
    .req_ready(req_ready[1]), .req_expect(req_expect[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_idx(out_idx[1]), .out_ready(out_ready),
    .err_multi(err_multi[1]), .err_none(err_none[1]), .err_cnt(err_cnt[1]),
    .err_clr(err_clr));

  sel_arb_mux #(.N(4), .W(8), .MODE(2), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_data(req_data),
    .req_ready(req_ready[2]), .req_expect(req_expect[2]), .out_valid(out_valid[2]),
    .out_data(out_data[2]), .out_idx(out_idx[2]), .out_ready(out_ready),
    .err_multi(err_multi[2]), .err_none(err_none[2]), .err_cnt(err_cnt[2]),
    .err_clr(err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int d, input logic [1:0] idx, input logic [7:0] data);
    sb_q.push_back({2'(d), idx, data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every accepted output word against the queue.
  initial begin
    logic [11:0] got;
    logic [11:0] exp;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst && out_valid[k] && out_ready) begin
          got = {2'(k), out_idx[k], out_data[k]};
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got %0h expected none", got);
          end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
              fails++;
              $display("FAIL sb_word: got %0h expected %0h", got, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] oh;
    rst       = 1'b1;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    req_data  = 32'hD3C2B1A0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 4'b0000;
      req_expect[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check("rst_out_data", 32'(out_data[k]), 32'd0);
      check("rst_out_idx", 32'(out_idx[k]), 32'd0);
      check("rst_err_cnt", 32'(err_cnt[k]), 32'd0);
      check("rst_err_pulse", 32'(err_multi[k] | err_none[k]), 32'd0);
    end
    step();

    // Fixed priority, back to back with overlapping requests
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = pv[i];
      sb_push(0, pix[i], 8'hA0 + 8'h11 * 8'(pix[i]));
      oh = 4'b0001 << pix[i];
      @(negedge clk);
      check("prio_ready", 32'(req_ready[0]), 32'(oh));
      check("prio_no_multi", 32'(err_multi[0]), 32'd0);
      step();
    end
    req_valid[0] = 4'b0000;
    @(negedge clk);
    check("prio_no_multi_end", 32'(err_multi[0]), 32'd0);
    step();
    step();

    // Unique: multi-hit then single request
    req_valid[1] = 4'b0110;
    sb_push(1, 2'd1, 8'hB1);
    @(negedge clk);
    check("uniq_ready_a", 32'(req_ready[1]), 32'h2);
    step();
    req_valid[1] = 4'b0100;
    sb_push(1, 2'd2, 8'hC2);
    @(negedge clk);
    check("uniq_multi_pulse", 32'(err_multi[1]), 32'd1);
    check("uniq_cnt_1", 32'(err_cnt[1]), 32'd1);
    check("uniq_ready_b", 32'(req_ready[1]), 32'h4);
    step();
    req_valid[1] = 4'b0000;
    @(negedge clk);
    check("uniq_multi_clear", 32'(err_multi[1]), 32'd0);
    check("uniq_cnt_hold", 32'(err_cnt[1]), 32'd1);
    step();

    // Round robin: all four, then channel 2 dropped
    for (int i = 0; i < 11; i++) begin
      req_valid[2] = rv[i];
      sb_push(2, rix[i], 8'hA0 + 8'h11 * 8'(rix[i]));
      oh = 4'b0001 << rix[i];
      @(negedge clk);
      check("rr_ready", 32'(req_ready[2]), 32'(oh));
      step();
    end

    // Backpressure: stall 3 cycles with new data pending on channel 0
    out_ready = 1'b0;
    req_data  = 32'hD3C2B15A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready[2]), 32'd0);
      check("bp_valid", 32'(out_valid[2]), 32'd1);
      check("bp_idx", 32'(out_idx[2]), 32'd3);
      check("bp_data", 32'(out_data[2]), 32'hD3);
      step();
    end
    out_ready = 1'b1;
    sb_push(2, 2'd0, 8'h5A);
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready[2]), 32'h1);
    step();
    req_valid[2] = 4'b0000;
    req_data     = 32'hD3C2B1A0;
    @(negedge clk);
    step();
    step();

    // Full-case: single err_none pulse
    req_expect[0] = 1'b1;
    step();
    req_expect[0] = 1'b0;
    @(negedge clk);
    check("none_pulse", 32'(err_none[0]), 32'd1);
    check("none_cnt_1", 32'(err_cnt[0]), 32'd1);
    step();
    @(negedge clk);
    check("none_pulse_end", 32'(err_none[0]), 32'd0);
    check("none_cnt_hold", 32'(err_cnt[0]), 32'd1);

    // 300 more error cycles: 254 after 253, saturated 255 at the end
    req_expect[0] = 1'b1;
    repeat (253) step();
    @(negedge clk);
    check("sat_cnt_254", 32'(err_cnt[0]), 32'd254);
    repeat (47) step();
    @(negedge clk);
    check("sat_cnt_255", 32'(err_cnt[0]), 32'd255);
    check("sat_pulse", 32'(err_none[0]), 32'd1);

    // Clear wins over same-cycle error
    err_clr = 1'b1;
    step();
    err_clr       = 1'b0;
    req_expect[0] = 1'b0;
    @(negedge clk);
    check("clr_cnt", 32'(err_cnt[0]), 32'd0);
    check("clr_pulse", 32'(err_none[0]), 32'd1);
    step();
    @(negedge clk);
    check("clr_cnt_hold", 32'(err_cnt[0]), 32'd0);
    step();

    // Reset mid-transfer in round-robin mode
    req_expect[2] = 1'b1;
    step();
    req_expect[2] = 1'b0;
    out_ready     = 1'b0;
    req_valid[2]  = 4'b1111;
    @(negedge clk);
    check("rr_err_cnt_pre", 32'(err_cnt[2]), 32'd1);
    check("rr_pre_ready", 32'(req_ready[2]), 32'h2);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rr_held_valid", 32'(out_valid[2]), 32'd1);
    check("rst_ready_zero", 32'(req_ready[2]), 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    sb_push(2, 2'd0, 8'hA0);
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid[2]), 32'd0);
    check("post_rst_cnt", 32'(err_cnt[2]), 32'd0);
    check("post_rst_ready", 32'(req_ready[2]), 32'h1);
    step();
    req_valid[2] = 4'b0000;
    @(negedge clk);
    step();
    step();

    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sel_arb_mux.md
# sel_arb_mux

Parametrised N-channel selection multiplexer with a registered, valid/ready-handshaked output. It is the synthesisable generalisation of our full/parallel-case mux: a compile-time mode picks fixed-priority (first match wins), unique (first match wins plus a multi-hit check), or round-robin selection. Full-case and parallel-case violations are raised as run-time error pulses and a saturating counter instead of being left to synthesis as don't-cares. It sits between request sources and a single downstream consumer wherever a case-style selector was previously hand-coded.

## Interface
- N, 4, number of request channels (2..16)
- W, 8, data width per channel
- MODE, 0, 0 = PRIORITY, 1 = UNIQUE, 2 = ROUND_ROBIN
- CNT_W, 8, width of the error counter
- IW, $clog2(N), index width (derived, not overridden)
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  per-channel request
- req_data  in  N*W  channel i occupies bits [i*W +: W]
- req_ready  out  N  one-hot grant, combinational
- req_expect  in  1  a selection is required this cycle (full-case check)
- out_valid  out  1  output register holds data
- out_data  out  W  selected data
- out_idx  out  IW  index of the selected channel
- out_ready  in  1  downstream accepts out_data
- err_multi  out  1  one-cycle pulse: UNIQUE mode, more than one request at grant
- err_none  out  1  one-cycle pulse: req_expect high with no req_valid at an open slot
- err_cnt  out  CNT_W  saturating count of error pulses
- err_clr  in  1  synchronous clear of err_cnt

## Operation
- load_en = !out_valid || out_ready.
- Grant occurs when load_en && |req_valid. Exactly one req_ready bit is high, for the granted channel g. On the same edge: out_data <= req_data[g], out_idx <= g, out_valid <= 1.
- load_en && !(|req_valid): out_valid <= 0 (if out_ready) or holds; out_data and out_idx hold.
- !load_en: req_ready = 0, output registers hold, no error checks.
- PRIORITY: g = lowest set index; overlapping requests are legal.
- UNIQUE: g = lowest set index; popcount(req_valid) > 1 at grant -> err_multi = 1 next cycle.
- ROUND_ROBIN: pointer p (IW bits). g = first set index searching p+1, p+2, ... with wrap N-1 -> 0. On grant, p <= g; otherwise p holds.
- err_none: load_en && req_expect && !(|req_valid) -> err_none = 1 next cycle. Checked in all modes.
- err_cnt increments by 1 per cycle in which err_multi or err_none is generated (both in one cycle counts once). It saturates at 2^CNT_W-1. err_clr wins over a same-cycle increment: result 0.
- Reset values: out_valid 0, out_data 0, out_idx 0, err_multi 0, err_none 0, err_cnt 0, p = N-1 (channel 0 is first in RR). req_ready = 0 while rst is high.
- Reset mid-transfer discards the held output word. No grant is issued during the reset cycle.

## Timing
- Grant is combinational in cycle t. Data is visible on out_* in cycle t+1. Latency is 1 cycle.
- Throughput is 1 word/cycle when out_ready stays high.
- Backpressure: out_valid && !out_ready holds out_data and out_idx stable and blocks all grants.
- Error pulses are registered, appear 1 cycle after the causing grant/check cycle, and last exactly 1 cycle.
- A requester must hold req_valid and req_data until it sees its req_ready bit. The arbiter never drops a granted word.

## Test plan
- PRIORITY, N=4: req_valid=4'b1010, out_ready=1 -> req_ready=4'b0010. Next cycle out_idx=1 and out_data=req_data[1]. err_multi stays 0.
- UNIQUE: req_valid=4'b0110 -> grant channel 1. Next cycle err_multi=1 for one cycle and err_cnt=1. Then req_valid=4'b0100 -> no error.
- ROUND_ROBIN: all four requests held, out_ready=1 -> out_idx sequence 0,1,2,3,0. Drop channel 2 -> sequence 3,0,1,3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0, out_data unchanged. Release -> the next grant occurs in the same cycle.
- Full-case: req_expect=1, req_valid=0, out_valid=0 -> err_none pulse. Repeat 300 times with CNT_W=8 -> err_cnt=255. Assert err_clr together with an error -> err_cnt=0.
- Reset: assert rst while out_valid=1 in RR mode -> next cycle out_valid=0 and err_cnt=0. With all requests high, the first grant after reset is channel 0.
